// File: rtl/lpc_io_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module      : lpc_io_dispatch_if
// Description : Bundle of the lpc_periph data-provider port, the per-device
//               register-bank bus and the device interrupt lines.
//               master : view taken by lpc_io_dispatch
//               slave  : view taken by lpc_periph plus the devices
//   lpc_addr_i/lpc_wdata_i/lpc_data_wr_i/lpc_data_req_i  request from lpc_periph
//   lpc_rdata_o/lpc_data_rd_o/lpc_wr_done_o              response to lpc_periph
//   irq_num_o/interrupt_o                                arbitrated interrupt
//   dev_stb_o/dev_we_o/dev_addr_o/dev_wdata_o            device access
//   dev_ack_i/dev_rdata_i/dev_irq_i/dev_irq_num_i        device replies
//   timeout_o                                            access timeout pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface lpc_io_dispatch_if #(
  parameter int NUM_DEV = 4
);
  logic [15:0]          lpc_addr_i;
  logic [7:0]           lpc_wdata_i;
  logic                 lpc_data_wr_i;
  logic                 lpc_data_req_i;
  logic [7:0]           lpc_rdata_o;
  logic                 lpc_data_rd_o;
  logic                 lpc_wr_done_o;
  logic [3:0]           irq_num_o;
  logic                 interrupt_o;
  logic [NUM_DEV-1:0]   dev_stb_o;
  logic                 dev_we_o;
  logic [15:0]          dev_addr_o;
  logic [7:0]           dev_wdata_o;
  logic [NUM_DEV-1:0]   dev_ack_i;
  logic [NUM_DEV*8-1:0] dev_rdata_i;
  logic [NUM_DEV-1:0]   dev_irq_i;
  logic [NUM_DEV*4-1:0] dev_irq_num_i;
  logic                 timeout_o;

  modport master (
    input  lpc_addr_i, lpc_wdata_i, lpc_data_wr_i, lpc_data_req_i,
    input  dev_ack_i, dev_rdata_i, dev_irq_i, dev_irq_num_i,
    output lpc_rdata_o, lpc_data_rd_o, lpc_wr_done_o, irq_num_o, interrupt_o,
    output dev_stb_o, dev_we_o, dev_addr_o, dev_wdata_o, timeout_o
  );

  modport slave (
    output lpc_addr_i, lpc_wdata_i, lpc_data_wr_i, lpc_data_req_i,
    output dev_ack_i, dev_rdata_i, dev_irq_i, dev_irq_num_i,
    input  lpc_rdata_o, lpc_data_rd_o, lpc_wr_done_o, irq_num_o, interrupt_o,
    input  dev_stb_o, dev_we_o, dev_addr_o, dev_wdata_o, timeout_o
  );
endinterface
`default_nettype wire

// File: rtl/lpc_io_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : lpc_io_dispatch
// Description : Dispatches LPC I/O cycles from lpc_periph to NUM_DEV register
//               bank devices: address decode (lowest matching index wins),
//               strobe/ack sequencing, response back to lpc_periph, timeout of
//               dead devices, and interrupt arbitration onto one irq_num /
//               interrupt pair.
// Ports       : clk_i  - LPC clock, posedge
//               rst_i  - synchronous reset, active high
//               bus    - lpc_io_dispatch_if.master (LPC request/response,
//                        device bus, device interrupts, timeout pulse)
//               NUM_DEV must equal the NUM_DEV of the connected interface.
// Revision    : 1.0 - initial release
// ============================================================================
module lpc_io_dispatch #(
  parameter int                    NUM_DEV = 4,
  parameter logic [NUM_DEV*16-1:0] BASES   = '0,
  parameter logic [NUM_DEV*16-1:0] MASKS   = '1,
  parameter int                    TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  lpc_io_dispatch_if.master bus
);

  localparam int         c_IDX_W   = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_wr_q;
  logic                 r_req_q;
  logic                 r_dir;        // 1 = write cycle
  logic [15:0]          r_addr;
  logic [7:0]           r_wdata;
  logic [c_IDX_W-1:0]   r_sel;
  logic [NUM_DEV-1:0]   r_stb;
  logic                 r_we;
  logic [7:0]           r_rdata;
  logic                 r_data_rd;
  logic                 r_wr_done;
  logic                 r_timeout;
  logic [7:0]           r_tcnt;

  logic [c_IDX_W-1:0]   r_irq_owner;
  logic                 r_irq_valid;
  logic [3:0]           r_irq_num;
  logic                 r_interrupt;

  logic                 w_wr_rise;
  logic                 w_req_rise;
  logic                 w_req_lvl;
  logic [NUM_DEV-1:0]   w_hit_vec;
  logic                 w_hit;
  logic [c_IDX_W-1:0]   w_hit_idx;
  logic [NUM_DEV-1:0]   w_hit_onehot;
  logic                 w_ack_sel;
  logic [7:0]           w_rdata_sel;

  logic                 w_owner_irq;
  logic [c_IDX_W-1:0]   w_irq_low_idx;
  logic [3:0]           w_irq_low_num;
  logic                 w_irq_valid_nxt;
  logic [c_IDX_W-1:0]   w_irq_owner_nxt;
  logic                 w_irq_grant;

  // --------------------------------------------------------------------------
  // Request edge detection and level of the request matching the open cycle
  // --------------------------------------------------------------------------
  assign w_wr_rise  = bus.lpc_data_wr_i  & ~r_wr_q;
  assign w_req_rise = bus.lpc_data_req_i & ~r_req_q;
  assign w_req_lvl  = r_dir ? bus.lpc_data_wr_i : bus.lpc_data_req_i;

  // --------------------------------------------------------------------------
  // Address decode against the latched address
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DEV; gi++) begin : g_decode
      assign w_hit_vec[gi] =
        ((r_addr ^ BASES[16*gi +: 16]) & MASKS[16*gi +: 16]) == 16'h0000;
    end
  endgenerate

  assign w_hit = |w_hit_vec;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    w_hit_idx    = '0;
    w_hit_onehot = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if (w_hit_vec[i]) begin
        w_hit_idx       = c_IDX_W'(i);
        w_hit_onehot    = '0;
        w_hit_onehot[i] = 1'b1;
      end
    end
  end

  // Ack and read data from the selected device only.
  always_comb begin
    w_ack_sel   = 1'b0;
    w_rdata_sel = 8'h00;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (r_sel == c_IDX_W'(i)) begin
        w_ack_sel   = bus.dev_ack_i[i];
        w_rdata_sel = bus.dev_rdata_i[8*i +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Access sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_wr_q    <= 1'b0;
      r_req_q   <= 1'b0;
      r_dir     <= 1'b0;
      r_addr    <= 16'h0000;
      r_wdata   <= 8'h00;
      r_sel     <= '0;
      r_stb     <= '0;
      r_we      <= 1'b0;
      r_rdata   <= 8'h00;
      r_data_rd <= 1'b0;
      r_wr_done <= 1'b0;
      r_timeout <= 1'b0;
      r_tcnt    <= 8'h00;
    end else begin
      r_wr_q    <= bus.lpc_data_wr_i;
      r_req_q   <= bus.lpc_data_req_i;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A write rising together with a read takes precedence.
          if (w_wr_rise) begin
            r_addr  <= bus.lpc_addr_i;
            r_wdata <= bus.lpc_wdata_i;
            r_dir   <= 1'b1;
            r_state <= S_DECODE;
          end else if (w_req_rise) begin
            r_addr  <= bus.lpc_addr_i;
            r_dir   <= 1'b0;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!w_req_lvl) begin
            r_state <= S_IDLE;
          end else if (w_hit) begin
            r_sel   <= w_hit_idx;
            r_stb   <= w_hit_onehot;
            r_we    <= r_dir;
            r_tcnt  <= 8'h00;
            r_state <= S_ACCESS;
          end else begin
            // Unclaimed address: reads float high, writes are dropped.
            r_rdata <= 8'hFF;
            r_state <= S_RESP;
          end
        end
        S_ACCESS: begin
          if (!w_req_lvl) begin
            r_stb   <= '0;
            r_we    <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_ack_sel) begin
            if (!r_dir) begin
              r_rdata <= w_rdata_sel;
            end
            r_stb   <= '0;
            r_we    <= 1'b0;
            r_state <= S_RESP;
          end else if (r_tcnt == c_TO_LAST) begin
            r_stb     <= '0;
            r_we      <= 1'b0;
            r_rdata   <= 8'hFF;
            r_timeout <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        S_RESP: begin
          // Response is raised one cycle after entering RESP and held until
          // lpc_periph drops the matching request.
          if (!w_req_lvl) begin
            r_data_rd <= 1'b0;
            r_wr_done <= 1'b0;
            r_state   <= S_IDLE;
          end else if (r_dir) begin
            r_wr_done <= 1'b1;
          end else begin
            r_data_rd <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Interrupt arbiter: a granted owner keeps the line until its own irq drops,
  // so irq_num_o never changes under an asserted interrupt.
  // --------------------------------------------------------------------------
  always_comb begin
    w_irq_low_idx = '0;
    w_irq_low_num = 4'h0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if (bus.dev_irq_i[i]) begin
        w_irq_low_idx = c_IDX_W'(i);
        w_irq_low_num = bus.dev_irq_num_i[4*i +: 4];
      end
    end
  end

  always_comb begin
    w_owner_irq = 1'b0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (r_irq_owner == c_IDX_W'(i)) begin
        w_owner_irq = bus.dev_irq_i[i];
      end
    end
  end

  // The owner releasing and a new grant never share an edge, which gives the
  // mandatory low cycle between owners.
  always_comb begin
    w_irq_valid_nxt = r_irq_valid;
    w_irq_owner_nxt = r_irq_owner;
    w_irq_grant     = 1'b0;
    if (r_irq_valid) begin
      if (!w_owner_irq) begin
        w_irq_valid_nxt = 1'b0;
      end
    end else if (|bus.dev_irq_i) begin
      w_irq_valid_nxt = 1'b1;
      w_irq_owner_nxt = w_irq_low_idx;
      w_irq_grant     = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_irq_owner <= '0;
      r_irq_valid <= 1'b0;
      r_irq_num   <= 4'h0;
      r_interrupt <= 1'b0;
    end else begin
      r_irq_owner <= w_irq_owner_nxt;
      r_irq_valid <= w_irq_valid_nxt;
      if (w_irq_grant) begin
        r_irq_num <= w_irq_low_num;
      end
      // A next-state owner always has its irq high, so valid alone suffices.
      r_interrupt <= w_irq_valid_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.lpc_rdata_o   = r_rdata;
  assign bus.lpc_data_rd_o = r_data_rd;
  assign bus.lpc_wr_done_o = r_wr_done;
  assign bus.irq_num_o     = r_irq_num;
  assign bus.interrupt_o   = r_interrupt;
  assign bus.dev_stb_o     = r_stb;
  assign bus.dev_we_o      = r_we;
  assign bus.dev_addr_o    = r_addr;
  assign bus.dev_wdata_o   = r_wdata;
  assign bus.timeout_o     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_lpc_io_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_lpc_io_dispatch
// Description : Self-checking bench for lpc_io_dispatch: vector table, random
//               transactions against an address-map reference model, and
//               hand sequences for abort, reset and interrupt arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lpc_io_dispatch;

  localparam int NDEV = 4;
  localparam int TO   = 4;
  localparam logic [NDEV*16-1:0] P_BASES = {16'h0080, 16'h0310, 16'h0060, 16'h0300};
  localparam logic [NDEV*16-1:0] P_MASKS = {16'hFFFC, 16'hFFF0, 16'hFFF0, 16'hFF00};

  // Reference address map, device index order.
  logic [15:0] ref_base [NDEV] = '{16'h0300, 16'h0060, 16'h0310, 16'h0080};
  logic [15:0] ref_mask [NDEV] = '{16'hFF00, 16'hFFF0, 16'hFFF0, 16'hFFFC};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lpc_io_dispatch_if #(.NUM_DEV(NDEV)) bus ();

  lpc_io_dispatch #(
    .NUM_DEV (NDEV),
    .BASES   (P_BASES),
    .MASKS   (P_MASKS),
    .TIMEOUT (TO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wd;
    int          dly;     // cycles after strobe seen before ack; >= TO means never
    logic [7:0]  ad;
    int          exp_dev; // -1 = no device
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int ref_decode(input logic [15:0] a);
    for (int i = 0; i < NDEV; i++) begin
      if ((a & ref_mask[i]) == (ref_base[i] & ref_mask[i])) return i;
    end
    return -1;
  endfunction

  // One complete LPC cycle: request, device reply, response, request release.
  task automatic xact(input bit we, input logic [15:0] addr, input logic [7:0] wd,
                      input int dly, input logic [7:0] ad, input int exp_dev,
                      input logic [7:0] exp_rd, input string tag);
    bit   timed;
    int   exp_lat;
    int   cyc;
    int   stb_first;
    int   resp_at;
    int   t_cnt;
    logic [NDEV-1:0] exp_stb;
    logic resp;
    timed   = (exp_dev >= 0) && (dly >= TO);
    exp_lat = (exp_dev < 0) ? 3 : (timed ? 3 + TO : 4 + dly);
    exp_stb = (exp_dev < 0) ? '0 : NDEV'(1 << exp_dev);
    @(negedge clk);
    bus.lpc_addr_i  = addr;
    bus.lpc_wdata_i = wd;
    bus.dev_rdata_i = {NDEV{~ad}};
    if (exp_dev >= 0) bus.dev_rdata_i[exp_dev*8 +: 8] = ad;
    if (we) bus.lpc_data_wr_i = 1'b1;
    else    bus.lpc_data_req_i = 1'b1;
    cyc = 0; stb_first = 0; resp_at = 0; t_cnt = 0;
    while (resp_at == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus.dev_ack_i = '0;
      if (bus.timeout_o) t_cnt++;
      if (bus.dev_stb_o != '0 && stb_first == 0) begin
        stb_first = cyc;
        check({tag, " stb"}, 32'(bus.dev_stb_o), 32'(exp_stb));
        check({tag, " we"}, 32'(bus.dev_we_o), 32'(we));
        check({tag, " addr"}, 32'(bus.dev_addr_o), 32'(addr));
        if (we) check({tag, " wdata"}, 32'(bus.dev_wdata_o), 32'(wd));
      end
      resp = we ? bus.lpc_wr_done_o : bus.lpc_data_rd_o;
      if (resp) begin
        resp_at = cyc;
      end else if (stb_first != 0 && exp_dev >= 0) begin
        if (!timed && cyc == stb_first + dly) bus.dev_ack_i[exp_dev] = 1'b1;
        else if (cyc == stb_first) bus.dev_ack_i[(exp_dev + 1) % NDEV] = 1'b1;
      end
    end
    bus.dev_ack_i = '0;
    check({tag, " latency"}, 32'(resp_at), 32'(exp_lat));
    check({tag, " stb_cycle"}, 32'(stb_first), (exp_dev < 0) ? 32'd0 : 32'd2);
    check({tag, " timeout_pulses"}, 32'(t_cnt), 32'(timed));
    if (!we) check({tag, " rdata"}, 32'(bus.lpc_rdata_o), 32'(exp_rd));
    check({tag, " other_resp"}, 32'(we ? bus.lpc_data_rd_o : bus.lpc_wr_done_o), 32'd0);
    @(negedge clk);
    check({tag, " resp_held"}, 32'(we ? bus.lpc_wr_done_o : bus.lpc_data_rd_o), 32'd1);
    bus.lpc_data_wr_i  = 1'b0;
    bus.lpc_data_req_i = 1'b0;
    @(negedge clk);
    check({tag, " resp_clear"}, 32'({bus.lpc_wr_done_o, bus.lpc_data_rd_o}), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    int          dv;
    int          dl;
    bit          w;
    int          cnt;

    bus.lpc_addr_i     = '0;
    bus.lpc_wdata_i    = '0;
    bus.lpc_data_wr_i  = 1'b0;
    bus.lpc_data_req_i = 1'b0;
    bus.dev_ack_i      = '0;
    bus.dev_rdata_i    = '0;
    bus.dev_irq_i      = '0;
    bus.dev_irq_num_i  = '0;

    vecs[0] = '{1'b0, 16'h0064, 8'h00, 1, 8'hA5,  1, 8'hA5};
    vecs[1] = '{1'b1, 16'h0061, 8'h3C, 0, 8'h00,  1, 8'h00};
    vecs[2] = '{1'b0, 16'h1234, 8'h00, 0, 8'h11, -1, 8'hFF};
    vecs[3] = '{1'b0, 16'h0315, 8'h00, 0, 8'h5A,  0, 8'h5A};
    vecs[4] = '{1'b0, 16'h0082, 8'h00, 2, 8'h77,  3, 8'h77};
    vecs[5] = '{1'b0, 16'h0061, 8'h00, 9, 8'h22,  1, 8'hFF};
    vecs[6] = '{1'b1, 16'h0301, 8'h99, 9, 8'h00,  0, 8'h00};
    vecs[7] = '{1'b1, 16'hFFFF, 8'h42, 0, 8'h00, -1, 8'h00};
    vecs[8] = '{1'b0, 16'h0300, 8'h00, 3, 8'hC3,  0, 8'hC3};
    vecs[9] = '{1'b0, 16'h0083, 8'h00, 4, 8'h66,  3, 8'hFF};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset outputs",
          {bus.lpc_rdata_o, bus.lpc_data_rd_o, bus.lpc_wr_done_o, bus.irq_num_o,
           bus.interrupt_o, bus.dev_stb_o, bus.dev_we_o, bus.timeout_o}, 32'd0);
    check("reset dev_addr", 32'(bus.dev_addr_o), 32'd0);
    check("reset dev_wdata", 32'(bus.dev_wdata_o), 32'd0);

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      xact(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].dly, vecs[i].ad,
           vecs[i].exp_dev, vecs[i].exp_rd, $sformatf("vec%0d", i));
    end

    // Random transactions against the reference map
    for (int k = 0; k < 40; k++) begin
      dv = $urandom_range(0, NDEV);
      if (dv == NDEV) a = 16'($urandom);
      else a = (ref_base[dv] & ref_mask[dv]) | (16'($urandom) & ~ref_mask[dv]);
      d  = 8'($urandom);
      dl = $urandom_range(0, TO + 1);
      w  = 1'($urandom_range(0, 1));
      dv = ref_decode(a);
      xact(w, a, 8'($urandom), dl, d, dv, (dv < 0 || dl >= TO) ? 8'hFF : d,
           $sformatf("rnd%0d", k));
    end

    // Abort: read request dropped while the device is strobed
    @(negedge clk);
    bus.lpc_addr_i     = 16'h0065;
    bus.lpc_data_req_i = 1'b1;
    cnt = 0;
    while (bus.dev_stb_o == '0 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("abort stb_seen", 32'(bus.dev_stb_o), 32'h2);
    bus.lpc_data_req_i = 1'b0;
    @(negedge clk);
    check("abort stb_drop", 32'(bus.dev_stb_o), 32'd0);
    cnt = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (bus.lpc_data_rd_o) cnt++;
    end
    check("abort no_resp", 32'(cnt), 32'd0);

    // Reset during ACCESS
    bus.lpc_addr_i    = 16'h0300;
    bus.lpc_wdata_i   = 8'h5E;
    bus.lpc_data_wr_i = 1'b1;
    cnt = 0;
    while (bus.dev_stb_o == '0 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("rst stb_seen", 32'(bus.dev_stb_o), 32'h1);
    rst = 1'b1;
    bus.lpc_data_wr_i = 1'b0;
    @(negedge clk);
    check("rst outputs",
          {bus.lpc_rdata_o, bus.lpc_data_rd_o, bus.lpc_wr_done_o, bus.irq_num_o,
           bus.interrupt_o, bus.dev_stb_o, bus.dev_we_o, bus.timeout_o}, 32'd0);
    check("rst addr_wdata", {bus.dev_addr_o, bus.dev_wdata_o}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Interrupt arbitration
    bus.dev_irq_num_i = {4'h5, 4'h4, 4'h5, 4'h1};
    check("irq idle", 32'(bus.interrupt_o), 32'd0);
    bus.dev_irq_i[2] = 1'b1;
    @(negedge clk);
    check("irq dev2 grant", {bus.interrupt_o, bus.irq_num_o}, {1'b1, 4'h4});
    bus.dev_irq_i[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("irq dev2 held", {bus.interrupt_o, bus.irq_num_o}, {1'b1, 4'h4});
    bus.dev_irq_i[2] = 1'b0;
    @(negedge clk);
    check("irq gap", {bus.interrupt_o, bus.irq_num_o}, {1'b0, 4'h4});
    @(negedge clk);
    check("irq dev0 grant", {bus.interrupt_o, bus.irq_num_o}, {1'b1, 4'h1});
    bus.dev_irq_i[0] = 1'b0;
    @(negedge clk);
    check("irq dev0 drop", 32'(bus.interrupt_o), 32'd0);
    bus.dev_irq_i[1] = 1'b1;
    bus.dev_irq_i[3] = 1'b1;
    @(negedge clk);
    check("irq eq first", {bus.interrupt_o, bus.irq_num_o}, {1'b1, 4'h5});
    bus.dev_irq_i[1] = 1'b0;
    @(negedge clk);
    check("irq eq gap", 32'(bus.interrupt_o), 32'd0);
    @(negedge clk);
    check("irq eq second", {bus.interrupt_o, bus.irq_num_o}, {1'b1, 4'h5});
    bus.dev_irq_i[3] = 1'b0;
    @(negedge clk);
    check("irq all drop", 32'(bus.interrupt_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
